// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Round-robin pick: on contention the requester that did not own the bus last wins.
    function automatic logic pick_owner(input logic if_m, input logic dm_m, input logic last_own);
        logic own;
        if (if_m && dm_m) begin
            own = (last_own == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dm_m) begin
            own = OWN_DM;
        end else begin
            own = OWN_IF;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter that flags a memory transaction which never completes.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // expired is combinational so the abort lands in the TIMEOUT-th busy cycle, not one later.
    assign expired = enable && (count_r == CNT_W'(TIMEOUT - 1));

    // Count busy cycles; saturates once expired so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between IF fetch and MEM load/store.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 15,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_error
);

    logic [1:0]        state_r;
    logic              last_own_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              if_valid_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              dm_valid_r;
    logic              bus_error_r;

    logic              if_req_m_s;
    logic              dm_req_m_s;
    logic              grant_any_s;
    logic              grant_own_s;
    logic              busy_s;
    logic              wd_expired_s;

    // A requester in its own completion cycle still has its level request up; mask it.
    always_comb begin
        if_req_m_s  = if_req & ~if_valid_r;
        dm_req_m_s  = (dm_read | dm_write) & ~dm_valid_r;
        grant_any_s = if_req_m_s | dm_req_m_s;
        grant_own_s = pick_owner(if_req_m_s, dm_req_m_s, last_own_r);
        busy_s      = (state_r != IDLE);
    end

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (~busy_s),
        .enable  (busy_s),
        .expired (wd_expired_s)
    );

    // Arbitration FSM, memory handshake registers and completion/return path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            last_own_r  <= OWN_IF;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_rdata_r  <= '0;
            if_valid_r  <= 1'b0;
            dm_rdata_r  <= '0;
            dm_valid_r  <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            if_valid_r <= 1'b0;
            dm_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        mem_req_r  <= 1'b1;
                        last_own_r <= grant_own_s;
                        if (grant_own_s == OWN_DM) begin
                            mem_addr_r  <= dm_addr;
                            mem_wdata_r <= dm_wdata;
                            mem_we_r    <= dm_write;
                            state_r     <= BUSY_DM;
                        end else begin
                            mem_addr_r <= if_addr;
                            mem_we_r   <= 1'b0;
                            state_r    <= BUSY_IF;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        if_rdata_r <= mem_rdata;
                        if_valid_r <= 1'b1;
                        mem_req_r  <= 1'b0;
                        state_r    <= IDLE;
                    end else if (wd_expired_s) begin
                        if_rdata_r  <= NOP_INSTR;
                        if_valid_r  <= 1'b1;
                        bus_error_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= BUSY_IF;
                    end
                end
                BUSY_DM: begin
                    // Stores leave dm_rdata untouched, both on completion and on abort.
                    if (mem_ready) begin
                        if (!mem_we_r) begin
                            dm_rdata_r <= mem_rdata;
                        end else begin
                            dm_rdata_r <= dm_rdata_r;
                        end
                        dm_valid_r <= 1'b1;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        state_r    <= IDLE;
                    end else if (wd_expired_s) begin
                        if (!mem_we_r) begin
                            dm_rdata_r <= '0;
                        end else begin
                            dm_rdata_r <= dm_rdata_r;
                        end
                        dm_valid_r  <= 1'b1;
                        bus_error_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= BUSY_DM;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_valid  = dm_valid_r;
    assign bus_error = bus_error_r;

    // Stalls must release in the completion cycle itself, hence combinational.
    assign stall_if  = if_req & ~if_valid_r;
    assign stall_mem = (dm_read | dm_write) & ~dm_valid_r;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store path of the 5-stage RISC-V pipeline. Arbitrates round-robin on contention, holds the memory handshake for variable latency, and returns read data with a one-cycle valid pulse. Drives the stall_if and stall_mem signals, which the hazard logic ORs into PC_write, IF_ID_write and the pipeline-register enables. A watchdog aborts hung transactions and raises a sticky error.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, max cycles in a busy state waiting for mem_ready before abort (≥1)
NOP_INSTR, 32'h00000013, instruction returned to IF on timeout (addi x0,x0,0)

Ports:
clk  in  1  global clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address (PC_IF)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle completion pulse for fetch
dm_read  in  1  load request, level, held until dm_valid
dm_write  in  1  store request, level, held until dm_valid
dm_addr  in  ADDR_W  data address (ALU_OUT_MEM)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data
dm_valid  out  1  one-cycle completion pulse for load/store
mem_req  out  1  memory transaction active
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, one cycle
stall_if  out  1  fetch pending, not yet completed
stall_mem  out  1  data access pending, not yet completed
bus_error  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM. Registered owner bit last_own (IF=0, DM=1).
- Reset (reset=0, async): state IDLE; last_own=IF; mem_req, mem_we, if_valid, dm_valid, bus_error = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; watchdog = 0. An in-flight transaction is dropped and mem_req falls immediately.
- IDLE request masking: a requester whose *_valid is high this cycle is masked, because its request is still up in the completion cycle.
- IDLE grant, single unmasked request: grant it.
- IDLE grant, both unmasked: grant the requester that is not last_own. Because last_own resets to IF, the first contention goes to DM.
- On grant at edge N: latch the address. For DM, also latch wdata and set mem_we=dm_write. Set last_own to the grantee, go to BUSY_*, and drive mem_req=1 from cycle N+1.
- dm_read and dm_write both high: treated as a write; dm_rdata is not updated.
- BUSY_*: mem_req, mem_we, mem_addr and mem_wdata are held stable. The watchdog increments every busy cycle.
- mem_ready in BUSY_IF: capture if_rdata=mem_rdata, pulse if_valid next cycle, return to IDLE.
- mem_ready in BUSY_DM: on a read, capture dm_rdata; on a write, dm_rdata is unchanged. Pulse dm_valid, return to IDLE.
- Minimum latency: request seen in cycle N → mem_req N+1 → mem_ready N+1 at earliest → valid N+2 → next grant possible N+2.
- mem_ready in IDLE is ignored.
- Timeout: watchdog reaching TIMEOUT without mem_ready sets bus_error (sticky until reset) and drops mem_req. It still pulses the owner's valid: if_rdata=NOP_INSTR, or dm_rdata=0 on a read. State returns to IDLE.
- mem_ready arriving in the same cycle as timeout: ready wins, no error.
- Stalls are combinational:
  - stall_if = if_req & ~if_valid
  - stall_mem = (dm_read|dm_write) & ~dm_valid
- Request withdrawn while busy (e.g. flush): the transaction completes, and the valid pulse still fires and is ignored upstream.
- Outputs are glitch-free registers, except the stall signals.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY_IF, BUSY_DM}
  - owner constants OWN_IF=0, OWN_DM=1
  - NOP_INSTR default
- Sub-module mem_watchdog: counter with clear/enable, parameter TIMEOUT, output expired.

Test Plan:
- Reset, then if_req with if_addr=0x0, memory replies ready after 1 cycle with 0x00500093 → mem_req at N+1, if_valid pulse at N+2, if_rdata=0x00500093, stall_if low after.
- if_req and dm_read raised together from reset → DM granted first (mem_addr=dm_addr), then IF next. Repeated contention alternates DM, IF, DM, IF.
- dm_write addr=0x10, wdata=0xDEADBEEF, ready after 3 cycles → mem_we=1 for 3 cycles with stable addr/wdata, dm_valid pulses once, dm_rdata unchanged.
- No mem_ready for TIMEOUT=15 cycles on a fetch → bus_error=1, if_rdata=0x00000013, if_valid pulse. bus_error stays 1 across later good transactions.
- reset low mid BUSY_DM → mem_req, valids and bus_error drop asynchronously. After release, state is IDLE and a pending if_req is granted.
- Request held high in the if_valid cycle → not re-granted that cycle. The next grant goes to the other waiting requester, or IDLE holds if none.
